// File: rtl/dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// dmem_mmio_responder
//   Data-memory responder for the pipelined core. It decodes the core's byte
//   address into a word RAM region (ALUResultM[31]=0) and an MMIO region
//   (ALUResultM[31]=1). The MMIO region has a TX byte FIFO feeding a debug
//   console and a free-running 32-bit timer with a compare interrupt.
//   Reads are combinational and writes are clocked.
//
// Ports
//   clk         in   1      rising-edge clock for all state
//   reset       in   1      synchronous, active-high
//   ALUResultM  in   Width  byte address (bits [1:0] ignored)
//   MemWriteM   in   1      write strobe
//   WriteDataM  in   Width  write data
//   ReadDataM   out  Width  combinational read data
//   tx_data     out  8      FIFO head byte (meaningful only while tx_valid)
//   tx_valid    out  1      FIFO not empty
//   tx_ready    in   1      console accepts the head byte this cycle
//   timer_irq   out  1      registered, level-type timer interrupt
//
// MMIO map (word index ALUResultM[4:2])
//   0 TXDATA  1 STATUS {ovf,full,empty,irq}  2 MTIME  3 MTIMECMP  4 CTRL  5-7 zero
// -----------------------------------------------------------------------------
module dmem_mmio_responder #(
  parameter int Width     = 32,
  parameter int AddrBits  = 10,
  parameter int FifoDepth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] ALUResultM,
  input  logic             MemWriteM,
  input  logic [Width-1:0] WriteDataM,
  output logic [Width-1:0] ReadDataM,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             timer_irq
);

  localparam int PtrBits = $clog2(FifoDepth);
  localparam int CntBits = $clog2(FifoDepth + 1);
  localparam int RamWords = 1 << AddrBits;

  localparam logic [2:0] REG_TXDATA   = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_MTIME    = 3'd2;
  localparam logic [2:0] REG_MTIMECMP = 3'd3;
  localparam logic [2:0] REG_CTRL     = 3'd4;

  localparam logic [CntBits-1:0] CNT_FULL = CntBits'(FifoDepth);

  // Storage (no reset: RAM contents survive reset, FIFO slots are don't-care)
  logic [Width-1:0]   ram_r [RamWords];
  logic [7:0]         fifo_r [FifoDepth];

  // Control state
  logic [PtrBits-1:0] wr_ptr_r;
  logic [PtrBits-1:0] rd_ptr_r;
  logic [CntBits-1:0] count_r;
  logic               ovf_r;
  logic [Width-1:0]   mtime_r;
  logic [Width-1:0]   mtimecmp_r;
  logic               ctrl_en_r;
  logic               timer_irq_r;

  // Decode
  logic               mmio_sel_s;
  logic [2:0]         reg_idx_s;
  logic [AddrBits-1:0] ram_idx_s;
  logic               we_ram_s;
  logic               we_reg_s;
  logic               push_req_s;
  logic               ovf_clr_s;
  logic               mtime_we_s;
  logic               mtimecmp_we_s;
  logic               ctrl_we_s;

  // FIFO handshake
  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               ovf_set_s;
  logic [Width-1:0]   status_s;
  logic               unused_s;

  assign mmio_sel_s = ALUResultM[Width-1];
  assign reg_idx_s  = ALUResultM[4:2];
  assign ram_idx_s  = ALUResultM[AddrBits+1:2];
  assign we_ram_s   = MemWriteM & ~mmio_sel_s;
  assign we_reg_s   = MemWriteM & mmio_sel_s;

  // Address bits that only alias or select the byte lane
  assign unused_s = ^{ALUResultM[Width-2:AddrBits+2], ALUResultM[1:0]};

  assign empty_s  = (count_r == {CntBits{1'b0}});
  assign full_s   = (count_r == CNT_FULL);
  assign pop_s    = ~empty_s & tx_ready;
  // A full FIFO can still accept a byte when the head leaves in the same cycle
  assign push_ok_s = push_req_s & (~full_s | pop_s);
  assign ovf_set_s = push_req_s & full_s & ~pop_s;

  assign tx_valid  = ~empty_s;
  assign tx_data   = fifo_r[rd_ptr_r];
  assign timer_irq = timer_irq_r;
  assign status_s  = {{(Width-4){1'b0}}, ovf_r, full_s, empty_s, timer_irq_r};

  // MMIO write strobes per register
  always_comb begin
    push_req_s    = 1'b0;
    ovf_clr_s     = 1'b0;
    mtime_we_s    = 1'b0;
    mtimecmp_we_s = 1'b0;
    ctrl_we_s     = 1'b0;
    if (we_reg_s) begin
      case (reg_idx_s)
        REG_TXDATA:   push_req_s    = 1'b1;
        REG_STATUS:   ovf_clr_s     = WriteDataM[3];
        REG_MTIME:    mtime_we_s    = 1'b1;
        REG_MTIMECMP: mtimecmp_we_s = 1'b1;
        REG_CTRL:     ctrl_we_s     = 1'b1;
        default:      push_req_s    = 1'b0;
      endcase
    end else begin
      push_req_s = 1'b0;
    end
  end

  // Read data mux
  always_comb begin
    ReadDataM = {Width{1'b0}};
    if (mmio_sel_s) begin
      case (reg_idx_s)
        REG_TXDATA:   ReadDataM = {Width{1'b0}};
        REG_STATUS:   ReadDataM = status_s;
        REG_MTIME:    ReadDataM = mtime_r;
        REG_MTIMECMP: ReadDataM = mtimecmp_r;
        REG_CTRL:     ReadDataM = {{(Width-1){1'b0}}, ctrl_en_r};
        default:      ReadDataM = {Width{1'b0}};
      endcase
    end else begin
      ReadDataM = ram_r[ram_idx_s];
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (we_ram_s) begin
      ram_r[ram_idx_s] <= WriteDataM;
    end
  end

  // FIFO slot write; reset only needs to clear the pointers and count
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      fifo_r[wr_ptr_r] <= WriteDataM[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PtrBits{1'b0}};
      rd_ptr_r <= {PtrBits{1'b0}};
      count_r  <= {CntBits{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PtrBits'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrBits'(1);
      end
      count_r <= count_r + CntBits'(push_ok_s) - CntBits'(pop_s);
      // A new overflow outranks a clear arriving in the same cycle
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  // Timer counter, compare, enable and registered interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_r     <= {Width{1'b0}};
      mtimecmp_r  <= {Width{1'b1}};
      ctrl_en_r   <= 1'b0;
      timer_irq_r <= 1'b0;
    end else begin
      if (mtime_we_s) begin
        mtime_r <= WriteDataM;
      end else begin
        mtime_r <= mtime_r + Width'(1);
      end
      if (mtimecmp_we_s) begin
        mtimecmp_r <= WriteDataM;
      end
      if (ctrl_we_s) begin
        ctrl_en_r <= WriteDataM[0];
      end
      // Compare uses the current register values, so irq lags mtime by one cycle
      timer_irq_r <= ctrl_en_r & (mtime_r >= mtimecmp_r);
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio_responder
//   Directed bench for dmem_mmio_responder. The stimulus process drives one
//   bus cycle per task call and queues the expected response; a monitor on the
//   falling edge pops and compares whenever a check is flagged or a TX byte is
//   handed to the console.
// -----------------------------------------------------------------------------
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_TX    = 32'h8000_0000;
  localparam logic [31:0] A_STAT  = 32'h8000_0004;
  localparam logic [31:0] A_MTIME = 32'h8000_0008;
  localparam logic [31:0] A_CMP   = 32'h8000_000C;
  localparam logic [31:0] A_CTRL  = 32'h8000_0010;
  localparam logic [31:0] A_RSV   = 32'h8000_0014;

  localparam int K_RDATA = 0;
  localparam int K_IRQ   = 1;
  localparam int K_TXV   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM;
  logic        MemWriteM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_val[$];
  int          sb_kind[$];
  string       sb_name[$];
  logic [7:0]  tx_q[$];

  logic chk_req;
  int   chk_kind;
  logic rdy_v;

  always #5 clk = ~clk;

  dmem_mmio_responder #(.Width(32), .AddrBits(10), .FifoDepth(8)) dut (
    .clk(clk),
    .reset(reset),
    .ALUResultM(ALUResultM),
    .MemWriteM(MemWriteM),
    .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .timer_irq(timer_irq)
  );

  // One bus cycle: drive just after the rising edge, optionally queue a check
  task automatic cyc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic req, input int kind, input logic [31:0] exp, input string name);
    @(posedge clk);
    #1;
    MemWriteM  = we;
    ALUResultM = addr;
    WriteDataM = wdata;
    tx_ready   = rdy_v;
    chk_req    = req;
    chk_kind   = kind;
    if (req) begin
      sb_val.push_back(exp);
      sb_kind.push_back(kind);
      sb_name.push_back(name);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(1'b1, addr, data, 1'b0, K_RDATA, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    cyc(1'b0, addr, 32'h0, 1'b1, K_RDATA, exp, name);
  endtask

  task automatic chk(input int kind, input logic [31:0] exp, input string name);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, kind, exp, name);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b0, K_RDATA, 32'h0, "");
  endtask

  task automatic set_reset(input logic v);
    @(posedge clk);
    #1;
    reset     = v;
    MemWriteM = 1'b0;
    tx_ready  = rdy_v;
    chk_req   = 1'b0;
  endtask

  // Monitor: compare flagged outputs and every byte the console accepts
  always @(negedge clk) begin
    logic [31:0] act;
    logic [31:0] v;
    int          k;
    string       n;
    logic [7:0]  eb;
    if (chk_req) begin
      checks++;
      if (sb_val.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: check flagged with nothing queued");
      end else begin
        v = sb_val.pop_front();
        k = sb_kind.pop_front();
        n = sb_name.pop_front();
        case (k)
          K_RDATA: act = ReadDataM;
          K_IRQ:   act = {31'b0, timer_irq};
          default: act = {31'b0, tx_valid};
        endcase
        if (act !== v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, act, v);
        end
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
      end else begin
        eb = tx_q.pop_front();
        if (tx_data !== eb) begin
          errors++;
          $display("FAIL tx_order: got %h expected %h", tx_data, eb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    MemWriteM  = 1'b0;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    tx_ready   = 1'b0;
    rdy_v      = 1'b0;
    chk_req    = 1'b0;
    chk_kind   = K_RDATA;

    // Reset state, observed while reset is held
    rd(A_MTIME, 32'h0000_0000, "rst_mtime");
    rd(A_CMP,   32'hFFFF_FFFF, "rst_mtimecmp");
    rd(A_STAT,  32'h0000_0002, "rst_status");
    rd(A_CTRL,  32'h0000_0000, "rst_ctrl");
    rd(A_RSV,   32'h0000_0000, "rst_reserved");
    chk(K_IRQ, 32'h0, "rst_irq");
    chk(K_TXV, 32'h0, "rst_txvalid");
    set_reset(1'b0);

    // 1: RAM write, aliasing, byte offset, read-during-write
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "t1_ram_rd");
    rd(32'h0000_1010, 32'hDEAD_BEEF, "t1_ram_alias");
    rd(32'h0000_0013, 32'hDEAD_BEEF, "t1_ram_byteoff");
    wr(32'h0000_0020, 32'h0000_0001);
    cyc(1'b1, 32'h0000_0020, 32'h0000_0002, 1'b1, K_RDATA, 32'h0000_0001, "t1_rd_during_wr");
    rd(32'h0000_0020, 32'h0000_0002, "t1_ram_new");
    rd(A_TX, 32'h0, "t1_txdata_reads_zero");

    // 2: fill, overflow, drain, W1C
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h41 + i);
    rd(A_STAT, 32'h0000_0004, "t2_status_full");
    wr(A_TX, 32'h49);
    rd(A_STAT, 32'h0000_000C, "t2_status_ovf");
    for (int i = 0; i < 8; i++) tx_q.push_back(8'h41 + 8'(i));
    rdy_v = 1'b1;
    for (int i = 0; i < 8; i++) chk(K_TXV, 32'h1, "t2_txvalid_drain");
    rd(A_STAT, 32'h0000_000A, "t2_status_empty_ovf");
    wr(A_STAT, 32'h0000_0008);
    rd(A_STAT, 32'h0000_0002, "t2_status_ovf_cleared");

    // 3: full FIFO with simultaneous push and pop
    rdy_v = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TX, 32'h50 + i);
    tx_q.push_back(8'h50);
    rdy_v = 1'b1;
    wr(A_TX, 32'h58);
    rdy_v = 1'b0;
    rd(A_STAT, 32'h0000_0004, "t3_status_still_full");
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'h50 + 8'(i));
    rdy_v = 1'b1;
    for (int i = 0; i < 8; i++) chk(K_TXV, 32'h1, "t3_txvalid_drain");
    rd(A_STAT, 32'h0000_0002, "t3_status_empty");

    // 4: compare interrupt rise and fall
    wr(A_CMP, 32'd20);
    wr(A_MTIME, 32'd0);
    wr(A_CTRL, 32'd1);
    rd(A_CTRL, 32'd1, "t4_ctrl");
    for (int i = 0; i < 17; i++) idle();
    chk(K_IRQ, 32'h0, "t4_irq_before");
    rd(A_MTIME, 32'd20, "t4_mtime_20");
    chk(K_IRQ, 32'h1, "t4_irq_rise");
    rd(A_STAT, 32'h0000_0003, "t4_status_irq");
    wr(A_CMP, 32'hFFFF_FFFF);
    chk(K_IRQ, 32'h1, "t4_irq_hold");
    chk(K_IRQ, 32'h0, "t4_irq_fall");

    // 5: load wins over increment, then wrap
    wr(A_MTIME, 32'hFFFF_FFFE);
    rd(A_MTIME, 32'hFFFF_FFFE, "t5_mtime_loaded");
    rd(A_MTIME, 32'hFFFF_FFFF, "t5_mtime_max");
    rd(A_MTIME, 32'h0000_0000, "t5_mtime_wrap");

    // 6: reset while draining
    rdy_v = 1'b0;
    wr(A_TX, 32'h61);
    wr(A_TX, 32'h62);
    wr(A_TX, 32'h63);
    tx_q.push_back(8'h61);
    rdy_v = 1'b1;
    chk(K_TXV, 32'h1, "t6_txvalid_before");
    tx_q.push_back(8'h62);
    set_reset(1'b1);
    chk(K_TXV, 32'h0, "t6_txvalid_after_reset");
    rd(A_MTIME, 32'h0000_0000, "t6_mtime");
    rd(A_CMP, 32'hFFFF_FFFF, "t6_mtimecmp");
    rd(A_CTRL, 32'h0000_0000, "t6_ctrl");
    chk(K_IRQ, 32'h0, "t6_irq");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "t6_ram_kept");
    rd(A_STAT, 32'h0000_0002, "t6_status");
    set_reset(1'b0);
    idle();
    idle();

    checks++;
    if (sb_val.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_val.size());
    end
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_leftover: got %0d undelivered bytes expected 0", tx_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
